// File: rtl/data_command_decoder.sv
// data_command_decoder: receives 32-bit commands over valid/ready into a
// small FIFO, decodes them by opcode and holds game/spike/config/ball state.
//
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   cmd_in/valid     command word and its valid; cmd_ready = FIFO not full
//   decode_enable    pop one FIFO entry per cycle while high
//   game_*           result, silent flag, win/lose counts, update pulse
//   spike_*          spike value and update pulse
//   group_func       2-bit function per electrode group; config_group/update
//   ball_*           ball X/Y and update pulse
//   cmd_error        malformed-command pulse; error_count saturates at 255
//   fifo_level       FIFO occupancy
module data_command_decoder #(
    parameter int CMD_WIDTH  = 32,
    parameter int DATA_WIDTH = 16,
    parameter int GROUPS     = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [CMD_WIDTH-1:0]          cmd_in,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          decode_enable,
    output logic                          game_result,
    output logic                          game_silent,
    output logic [7:0]                    win_count,
    output logic [7:0]                    lose_count,
    output logic                          game_update,
    output logic [DATA_WIDTH-1:0]         spike_value,
    output logic                          spike_update,
    output logic [2*GROUPS-1:0]           group_func,
    output logic [3:0]                    config_group,
    output logic                          config_update,
    output logic [7:0]                    ball_x,
    output logic [7:0]                    ball_y,
    output logic                          ball_update,
    output logic                          cmd_error,
    output logic [7:0]                    error_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] L_FULL = (AW+1)'(FIFO_DEPTH);

    localparam logic [3:0] OP_GAME  = 4'h1;
    localparam logic [3:0] OP_SPIKE = 4'h2;
    localparam logic [3:0] OP_CTRL  = 4'h3;
    localparam logic [3:0] OP_CFG   = 4'h4;

    logic [CMD_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [AW:0]          r_count;

    logic                 r_dec_valid;
    logic [CMD_WIDTH-1:0] r_dec_word;

    logic                 w_push;
    logic                 w_pop;
    logic [3:0]           w_op;
    logic [3:0]           w_grp;
    logic                 w_cfg_ok;

    assign cmd_ready  = (r_count != L_FULL);
    assign fifo_level = r_count;
    assign w_push     = cmd_valid && cmd_ready;
    assign w_pop      = decode_enable && (r_count != '0);

    // FIFO storage needs no reset; occupancy gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= cmd_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Popped word is staged one cycle, then decoded into the outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dec_valid <= 1'b0;
            r_dec_word  <= '0;
        end else begin
            r_dec_valid <= w_pop;
            if (w_pop) begin
                r_dec_word <= r_mem[r_rd_ptr];
            end
        end
    end

    assign w_op     = r_dec_word[31:28];
    assign w_grp    = r_dec_word[21:18];
    assign w_cfg_ok = (r_dec_word[25:22] == 4'b0001) &&
                      (int'(w_grp) < GROUPS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            game_result   <= 1'b0;
            game_silent   <= 1'b0;
            win_count     <= '0;
            lose_count    <= '0;
            game_update   <= 1'b0;
            spike_value   <= '0;
            spike_update  <= 1'b0;
            group_func    <= '0;
            config_group  <= '0;
            config_update <= 1'b0;
            ball_x        <= '0;
            ball_y        <= '0;
            ball_update   <= 1'b0;
            cmd_error     <= 1'b0;
            error_count   <= '0;
        end else begin
            game_update   <= 1'b0;
            spike_update  <= 1'b0;
            config_update <= 1'b0;
            ball_update   <= 1'b0;
            cmd_error     <= 1'b0;
            if (r_dec_valid) begin
                if (w_op == OP_GAME) begin
                    game_result <= r_dec_word[23];
                    game_silent <= r_dec_word[22];
                    win_count   <= r_dec_word[15:8];
                    lose_count  <= r_dec_word[7:0];
                    game_update <= 1'b1;
                end else if (w_op == OP_SPIKE) begin
                    spike_value  <= r_dec_word[DATA_WIDTH-1:0];
                    spike_update <= 1'b1;
                end else if (w_op == OP_CTRL) begin
                    ball_x      <= r_dec_word[15:8];
                    ball_y      <= r_dec_word[7:0];
                    ball_update <= 1'b1;
                end else if ((w_op == OP_CFG) && w_cfg_ok) begin
                    for (int g = 0; g < GROUPS; g++) begin
                        if (w_grp == 4'(g)) begin
                            group_func[2*g +: 2] <= r_dec_word[17:16];
                        end
                    end
                    config_group  <= w_grp;
                    config_update <= 1'b1;
                end else begin
                    cmd_error <= 1'b1;
                    if (error_count != 8'hFF) begin
                        error_count <= error_count + 8'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_data_command_decoder.sv
// tb_data_command_decoder: table vectors, corner-case sequences and random
// traffic checked against a queue-based command model.
module tb_data_command_decoder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cmd_in;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        decode_enable;
    logic        game_result, game_silent, game_update;
    logic [7:0]  win_count, lose_count;
    logic [15:0] spike_value;
    logic        spike_update;
    logic [19:0] group_func;
    logic [3:0]  config_group;
    logic        config_update;
    logic [7:0]  ball_x, ball_y;
    logic        ball_update;
    logic        cmd_error;
    logic [7:0]  error_count;
    logic [2:0]  fifo_level;

    always #5 clk = ~clk;

    data_command_decoder #(
        .CMD_WIDTH(32), .DATA_WIDTH(16), .GROUPS(10), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .cmd_in(cmd_in), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .decode_enable(decode_enable),
        .game_result(game_result), .game_silent(game_silent),
        .win_count(win_count), .lose_count(lose_count),
        .game_update(game_update), .spike_value(spike_value),
        .spike_update(spike_update), .group_func(group_func),
        .config_group(config_group), .config_update(config_update),
        .ball_x(ball_x), .ball_y(ball_y), .ball_update(ball_update),
        .cmd_error(cmd_error), .error_count(error_count),
        .fifo_level(fifo_level)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: accepted words, word in decode, visible results.
    logic [31:0] m_q[$];
    logic        m_pv;
    logic [31:0] m_pw;
    logic        m_res, m_sil;
    logic [7:0]  m_win, m_lose, m_bx, m_by, m_ec;
    logic [15:0] m_spk;
    logic [19:0] m_gf;
    logic [3:0]  m_cg;
    logic [4:0]  m_pulse;

    typedef struct {
        logic [31:0] cmd;
        int          kind;
        logic        res, sil;
        logic [7:0]  win, lose;
        logic [15:0] spk;
        logic [19:0] gf;
        logic [3:0]  cg;
        logic [7:0]  bx, by, ec;
    } vec_t;

    vec_t tbl[13];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] pulses();
        return {game_update, spike_update, config_update,
                ball_update, cmd_error};
    endfunction

    task automatic m_reset();
        m_q.delete();
        m_pv = 0; m_pw = '0;
        m_res = 0; m_sil = 0; m_win = 0; m_lose = 0;
        m_bx = 0; m_by = 0; m_ec = 0; m_spk = 0;
        m_gf = 0; m_cg = 0; m_pulse = 0;
    endtask

    task automatic m_apply(logic [31:0] w);
        int op;
        int grp;
        op = int'(w[31:28]);
        grp = int'(w[21:18]);
        if (op == 1) begin
            m_res = w[23]; m_sil = w[22];
            m_win = w[15:8]; m_lose = w[7:0];
            m_pulse = 5'b10000;
        end else if (op == 2) begin
            m_spk = w[15:0];
            m_pulse = 5'b01000;
        end else if (op == 3) begin
            m_bx = w[15:8]; m_by = w[7:0];
            m_pulse = 5'b00010;
        end else if (op == 4 && w[25:22] == 4'b0001 && grp < 10) begin
            m_gf[2*grp +: 2] = w[17:16];
            m_cg = w[21:18];
            m_pulse = 5'b00100;
        end else begin
            m_pulse = 5'b00001;
            if (m_ec != 8'd255) m_ec = m_ec + 8'd1;
        end
    endtask

    task automatic compare_all();
        check("fifo_level", 32'(fifo_level), 32'(m_q.size()));
        check("cmd_ready", 32'(cmd_ready), 32'(m_q.size() != DEPTH));
        check("pulses", 32'(pulses()), 32'(m_pulse));
        check("game_result", 32'(game_result), 32'(m_res));
        check("game_silent", 32'(game_silent), 32'(m_sil));
        check("win_count", 32'(win_count), 32'(m_win));
        check("lose_count", 32'(lose_count), 32'(m_lose));
        check("spike_value", 32'(spike_value), 32'(m_spk));
        check("group_func", 32'(group_func), 32'(m_gf));
        check("config_group", 32'(config_group), 32'(m_cg));
        check("ball_x", 32'(ball_x), 32'(m_bx));
        check("ball_y", 32'(ball_y), 32'(m_by));
        check("error_count", 32'(error_count), 32'(m_ec));
    endtask

    // Called at a negedge: drive, take one edge in DUT and model, compare.
    task automatic step(logic v, logic [31:0] d, logic de);
        bit rdy;
        bit pop;
        cmd_valid = v; cmd_in = d; decode_enable = de;
        @(posedge clk);
        rdy = (m_q.size() != DEPTH);
        m_pulse = 0;
        if (m_pv) m_apply(m_pw);
        pop = de && (m_q.size() != 0);
        m_pv = pop;
        if (pop) m_pw = m_q.pop_front();
        if (v && rdy) m_q.push_back(d);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(int n, logic de);
        for (int i = 0; i < n; i++) step(0, 32'h0, de);
    endtask

    function automatic logic [31:0] rand_cmd();
        logic [31:0] w;
        int sel;
        w = $urandom;
        sel = $urandom_range(0, 5);
        if (sel < 4) w[31:28] = 4'(sel + 1);
        if (sel == 3 && $urandom_range(0, 1) == 1) w[25:22] = 4'b0001;
        return w;
    endfunction

    initial begin
        logic [15:0] got[$];
        int idx;
        int sent;

        tbl[0]  = '{32'h1080_0503, 0, 1, 0, 8'h05, 8'h03, 16'h0000,
                    20'h00000, 4'd0, 8'h00, 8'h00, 8'd0};
        tbl[1]  = '{32'h404E_0000, 2, 1, 0, 8'h05, 8'h03, 16'h0000,
                    20'h00080, 4'd3, 8'h00, 8'h00, 8'd0};
        tbl[2]  = '{32'h4070_0000, 4, 1, 0, 8'h05, 8'h03, 16'h0000,
                    20'h00080, 4'd3, 8'h00, 8'h00, 8'd1};
        tbl[3]  = '{32'h2000_00FF, 1, 1, 0, 8'h05, 8'h03, 16'h00FF,
                    20'h00080, 4'd3, 8'h00, 8'h00, 8'd1};
        tbl[4]  = '{32'h3000_1234, 3, 1, 0, 8'h05, 8'h03, 16'h00FF,
                    20'h00080, 4'd3, 8'h12, 8'h34, 8'd1};
        tbl[5]  = '{32'h7000_0000, 4, 1, 0, 8'h05, 8'h03, 16'h00FF,
                    20'h00080, 4'd3, 8'h12, 8'h34, 8'd2};
        tbl[6]  = '{32'h3000_0000, 3, 1, 0, 8'h05, 8'h03, 16'h00FF,
                    20'h00080, 4'd3, 8'h00, 8'h00, 8'd2};
        tbl[7]  = '{32'h4080_0000, 4, 1, 0, 8'h05, 8'h03, 16'h00FF,
                    20'h00080, 4'd3, 8'h00, 8'h00, 8'd3};
        tbl[8]  = '{32'h2ABC_1234, 1, 1, 0, 8'h05, 8'h03, 16'h1234,
                    20'h00080, 4'd3, 8'h00, 8'h00, 8'd3};
        tbl[9]  = '{32'h15C0_FF01, 0, 1, 1, 8'hFF, 8'h01, 16'h1234,
                    20'h00080, 4'd3, 8'h00, 8'h00, 8'd3};
        tbl[10] = '{32'h4067_0000, 2, 1, 1, 8'hFF, 8'h01, 16'h1234,
                    20'hC0080, 4'd9, 8'h00, 8'h00, 8'd3};
        tbl[11] = '{32'h404F_0000, 2, 1, 1, 8'hFF, 8'h01, 16'h1234,
                    20'hC00C0, 4'd3, 8'h00, 8'h00, 8'd3};
        tbl[12] = '{32'h4068_0000, 4, 1, 1, 8'hFF, 8'h01, 16'h1234,
                    20'hC00C0, 4'd3, 8'h00, 8'h00, 8'd4};

        reset = 1; cmd_valid = 0; cmd_in = 0; decode_enable = 0;
        m_reset();
        @(negedge clk); @(negedge clk);
        compare_all();
        reset = 0;
        idle(2, 1);
        check("ready_after_reset", 32'(cmd_ready), 32'd1);

        // Table vectors: accept at edge N, pulse visible only after N+2.
        for (int i = 0; i < 13; i++) begin
            check("tbl_ready", 32'(cmd_ready), 32'd1);
            step(1, tbl[i].cmd, 1);
            step(0, 32'h0, 1);
            check("tbl_early_pulse", 32'(pulses()), 32'd0);
            step(0, 32'h0, 1);
            check("tbl_pulse", 32'(pulses()), 32'(5'b10000 >> tbl[i].kind));
            check("tbl_result", 32'(game_result), 32'(tbl[i].res));
            check("tbl_silent", 32'(game_silent), 32'(tbl[i].sil));
            check("tbl_win", 32'(win_count), 32'(tbl[i].win));
            check("tbl_lose", 32'(lose_count), 32'(tbl[i].lose));
            check("tbl_spike", 32'(spike_value), 32'(tbl[i].spk));
            check("tbl_gf", 32'(group_func), 32'(tbl[i].gf));
            check("tbl_cg", 32'(config_group), 32'(tbl[i].cg));
            check("tbl_bx", 32'(ball_x), 32'(tbl[i].bx));
            check("tbl_by", 32'(ball_y), 32'(tbl[i].by));
            check("tbl_ec", 32'(error_count), 32'(tbl[i].ec));
            step(0, 32'h0, 1);
            check("tbl_pulse_end", 32'(pulses()), 32'd0);
        end

        // Back-to-back stream: one pulse per cycle in order.
        step(1, 32'h2000_00FF, 1);
        step(1, 32'h3000_1234, 1);
        step(1, 32'h7000_0000, 1);
        check("stream_spike", 32'(pulses()), 32'b01000);
        check("stream_spike_val", 32'(spike_value), 32'h00FF);
        step(0, 32'h0, 1);
        check("stream_ball", 32'(pulses()), 32'b00010);
        check("stream_ball_xy", 32'({ball_x, ball_y}), 32'h1234);
        step(0, 32'h0, 1);
        check("stream_err", 32'(pulses()), 32'b00001);
        idle(2, 1);

        // Backpressure: decode frozen, six words offered, four fit.
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            bit acc;
            acc = cmd_ready;
            step(1, 32'h2000_0000 + 32'(idx), 0);
            if (acc) idx++;
        end
        check("bp_accepted", 32'(idx), 32'd4);
        check("bp_level", 32'(fifo_level), 32'd4);
        check("bp_ready", 32'(cmd_ready), 32'd0);
        for (int c = 0; c < 20 && idx < 6; c++) begin
            bit acc;
            acc = cmd_ready;
            step(1, 32'h2000_0000 + 32'(idx), 1);
            if (spike_update) got.push_back(spike_value);
            if (acc) idx++;
        end
        check("bp_all_sent", 32'(idx), 32'd6);
        for (int c = 0; c < 8; c++) begin
            step(0, 32'h0, 1);
            if (spike_update) got.push_back(spike_value);
        end
        check("bp_decodes", 32'(got.size()), 32'd6);
        for (int i = 0; i < got.size(); i++)
            check("bp_order", 32'(got[i]), 32'(i));

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            step(1'($urandom_range(0, 1)), rand_cmd(),
                 1'($urandom_range(0, 3) != 0));
        end
        idle(8, 1);

        // Error counter saturation.
        sent = 0;
        for (int c = 0; c < 400 && sent < 300; c++) begin
            bit acc;
            acc = cmd_ready;
            step(1, 32'hF000_0000 + 32'(c), 1);
            if (acc) sent++;
        end
        check("sat_sent", 32'(sent), 32'd300);
        idle(4, 1);
        check("sat_count", 32'(error_count), 32'd255);

        // Reset with three words buffered.
        idle(3, 1);
        step(1, 32'h1080_0503, 0);
        step(1, 32'h2000_0055, 0);
        step(1, 32'h3000_0102, 0);
        check("rst_buffered", 32'(fifo_level), 32'd3);
        #2 reset = 1;
        #1 m_reset();
        compare_all();
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_ec", 32'(error_count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        for (int c = 0; c < 5; c++) begin
            step(0, 32'h0, 1);
            check("rst_no_pulse", 32'(pulses()), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
